// File: rtl/udp_payload_capture_pkg.sv
// Shared definitions for the UDP payload capture block: FSM state encoding,
// port-filter mode encodings and the fixed UDP header size.
package udp_payload_capture_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StHold
  } state_e;

  // Port-filter rules applied to the UDP header ports.
  localparam logic [1:0] FilterAny      = 2'd0;
  localparam logic [1:0] FilterDst      = 2'd1;
  localparam logic [1:0] FilterSrcOrDst = 2'd2;
  localparam logic [1:0] FilterSrc      = 2'd3;

endpackage

// File: rtl/udp_payload_capture_if.sv
// Bundle of header, payload-stream, captured-packet and error signals.
// The slave view is the capture block; the master view is its environment.
interface udp_payload_capture_if #(
  parameter int unsigned MAX_BYTES = 512
);

  logic                   s_udp_hdr_valid;
  logic                   s_udp_hdr_ready;
  logic [15:0]            s_udp_source_port;
  logic [15:0]            s_udp_dest_port;
  logic [31:0]            s_udp_source_ip;
  logic [31:0]            s_udp_dest_ip;
  logic [15:0]            s_udp_length;

  logic [7:0]             s_udp_payload_axis_tdata;
  logic                   s_udp_payload_axis_tvalid;
  logic                   s_udp_payload_axis_tready;
  logic                   s_udp_payload_axis_tlast;
  logic                   s_udp_payload_axis_tuser;

  logic                   m_pkt_valid;
  logic                   m_pkt_ready;
  logic [15:0]            m_udp_source_port;
  logic [15:0]            m_udp_dest_port;
  logic [31:0]            m_udp_source_ip;
  logic [31:0]            m_udp_dest_ip;
  logic [15:0]            m_pkt_len;
  logic [8*MAX_BYTES-1:0] m_pkt_data;

  logic                   err_short;
  logic                   err_long;
  logic                   err_oversize;
  logic                   err_tuser;

  modport slave (
    input  s_udp_hdr_valid, s_udp_source_port, s_udp_dest_port, s_udp_source_ip,
           s_udp_dest_ip, s_udp_length,
    output s_udp_hdr_ready,
    input  s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid, s_udp_payload_axis_tlast,
           s_udp_payload_axis_tuser,
    output s_udp_payload_axis_tready,
    input  m_pkt_ready,
    output m_pkt_valid, m_udp_source_port, m_udp_dest_port, m_udp_source_ip, m_udp_dest_ip,
           m_pkt_len, m_pkt_data,
    output err_short, err_long, err_oversize, err_tuser
  );

  modport master (
    output s_udp_hdr_valid, s_udp_source_port, s_udp_dest_port, s_udp_source_ip,
           s_udp_dest_ip, s_udp_length,
    input  s_udp_hdr_ready,
    output s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid, s_udp_payload_axis_tlast,
           s_udp_payload_axis_tuser,
    input  s_udp_payload_axis_tready,
    output m_pkt_ready,
    input  m_pkt_valid, m_udp_source_port, m_udp_dest_port, m_udp_source_ip, m_udp_dest_ip,
           m_pkt_len, m_pkt_data,
    input  err_short, err_long, err_oversize, err_tuser
  );

endinterface

// File: rtl/udp_port_match.sv
// Combinational UDP port filter: decides whether a header's ports select the
// frame for capture under the configured filter rule.
module udp_port_match
  import udp_payload_capture_pkg::*;
#(
  parameter logic [15:0] FILTER_PORT = 16'd53,
  parameter logic [1:0]  FILTER_MODE = FilterSrcOrDst
) (
  input  logic [15:0] source_port_i,
  input  logic [15:0] dest_port_i,
  output logic        match_o
);

  logic src_hit;
  logic dst_hit;

  assign src_hit = (source_port_i == FILTER_PORT);
  assign dst_hit = (dest_port_i == FILTER_PORT);

  // Apply the selected match rule.
  always_comb begin
    match_o = 1'b0;
    unique case (FILTER_MODE)
      FilterAny:      match_o = 1'b1;
      FilterDst:      match_o = dst_hit;
      FilterSrcOrDst: match_o = src_hit | dst_hit;
      FilterSrc:      match_o = src_hit;
    endcase
  end

endmodule

// File: rtl/udp_payload_capture.sv
// Captures the payload of one filtered UDP frame into a flat byte buffer and
// presents it with the latched header fields until the consumer accepts it.
// Malformed frames are dropped with exactly one error pulse.
module udp_payload_capture
  import udp_payload_capture_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = 512,
  parameter logic [15:0] FILTER_PORT = 16'd53,
  parameter logic [1:0]  FILTER_MODE = FilterSrcOrDst
) (
  input logic                  clk,
  input logic                  rst,
  udp_payload_capture_if.slave udp_if
);

  localparam int unsigned IdxW     = $clog2(MAX_BYTES);
  localparam logic [15:0] MaxCount = 16'(MAX_BYTES);

  state_e                      state_q;
  logic                        hdr_ready_q;
  logic                        tready_q;
  logic                        pkt_valid_q;
  logic [15:0]                 pkt_len_q;
  logic [15:0]                 count_q;
  logic [15:0]                 expected_q;
  logic                        short_hdr_q;
  logic [15:0]                 src_port_q;
  logic [15:0]                 dst_port_q;
  logic [31:0]                 src_ip_q;
  logic [31:0]                 dst_ip_q;
  logic [MAX_BYTES-1:0][7:0]   buf_q;
  logic                        err_short_q;
  logic                        err_long_q;
  logic                        err_oversize_q;
  logic                        err_tuser_q;

  logic                        port_match;
  logic                        hdr_fire;
  logic                        beat_fire;
  logic                        tlast;
  logic [15:0]                 cnt_inc;
  logic [IdxW-1:0]             wr_idx;

  udp_port_match #(
    .FILTER_PORT (FILTER_PORT),
    .FILTER_MODE (FILTER_MODE)
  ) u_port_match (
    .source_port_i (udp_if.s_udp_source_port),
    .dest_port_i   (udp_if.s_udp_dest_port),
    .match_o       (port_match)
  );

  assign hdr_fire  = udp_if.s_udp_hdr_valid & hdr_ready_q;
  assign beat_fire = udp_if.s_udp_payload_axis_tvalid & tready_q;
  assign tlast     = udp_if.s_udp_payload_axis_tlast;
  assign cnt_inc   = count_q + 16'd1;
  // Byte 0 lives in the most significant lane of the buffer.
  assign wr_idx    = IdxW'(MAX_BYTES - 1) - count_q[IdxW-1:0];

  // Frame FSM: header accept, payload capture/drain, output hold, error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      hdr_ready_q    <= 1'b0;
      tready_q       <= 1'b0;
      pkt_valid_q    <= 1'b0;
      pkt_len_q      <= '0;
      count_q        <= '0;
      expected_q     <= '0;
      short_hdr_q    <= 1'b0;
      src_port_q     <= '0;
      dst_port_q     <= '0;
      src_ip_q       <= '0;
      dst_ip_q       <= '0;
      buf_q          <= '0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_oversize_q <= 1'b0;
      err_tuser_q    <= 1'b0;
    end else begin
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_oversize_q <= 1'b0;
      err_tuser_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          hdr_ready_q <= 1'b1;
          if (hdr_fire) begin
            hdr_ready_q <= 1'b0;
            tready_q    <= 1'b1;
            src_port_q  <= udp_if.s_udp_source_port;
            dst_port_q  <= udp_if.s_udp_dest_port;
            src_ip_q    <= udp_if.s_udp_source_ip;
            dst_ip_q    <= udp_if.s_udp_dest_ip;
            count_q     <= '0;
            buf_q       <= '0;
            if (udp_if.s_udp_length < 16'(UDP_HDR_BYTES)) begin
              // Impossible length: swallow the payload, flag it on the last beat.
              short_hdr_q <= 1'b1;
              expected_q  <= '0;
              state_q     <= StDrain;
            end else begin
              short_hdr_q <= 1'b0;
              expected_q  <= udp_if.s_udp_length - 16'(UDP_HDR_BYTES);
              state_q     <= port_match ? StCapture : StDrain;
            end
          end
        end
        StCapture: begin
          if (beat_fire) begin
            if (count_q != MaxCount) begin
              buf_q[wr_idx] <= udp_if.s_udp_payload_axis_tdata;
              count_q       <= cnt_inc;
            end
            if (tlast && udp_if.s_udp_payload_axis_tuser) begin
              err_tuser_q <= 1'b1;
              tready_q    <= 1'b0;
              hdr_ready_q <= 1'b1;
              state_q     <= StIdle;
            end else if (count_q == MaxCount) begin
              err_oversize_q <= 1'b1;
              if (tlast) begin
                tready_q    <= 1'b0;
                hdr_ready_q <= 1'b1;
                state_q     <= StIdle;
              end else begin
                state_q <= StDrain;
              end
            end else if (tlast && cnt_inc == expected_q) begin
              pkt_valid_q <= 1'b1;
              pkt_len_q   <= expected_q;
              tready_q    <= 1'b0;
              state_q     <= StHold;
            end else if (tlast) begin
              if (cnt_inc < expected_q) err_short_q <= 1'b1;
              else                      err_long_q  <= 1'b1;
              tready_q    <= 1'b0;
              hdr_ready_q <= 1'b1;
              state_q     <= StIdle;
            end else if (cnt_inc >= expected_q) begin
              err_long_q <= 1'b1;
              state_q    <= StDrain;
            end
          end
        end
        StDrain: begin
          if (beat_fire && tlast) begin
            err_short_q <= short_hdr_q;
            short_hdr_q <= 1'b0;
            tready_q    <= 1'b0;
            hdr_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StHold: begin
          if (udp_if.m_pkt_ready) begin
            pkt_valid_q <= 1'b0;
            hdr_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign udp_if.s_udp_hdr_ready           = hdr_ready_q;
  assign udp_if.s_udp_payload_axis_tready = tready_q;
  assign udp_if.m_pkt_valid               = pkt_valid_q;
  assign udp_if.m_pkt_len                 = pkt_len_q;
  assign udp_if.m_pkt_data                = buf_q;
  assign udp_if.m_udp_source_port         = src_port_q;
  assign udp_if.m_udp_dest_port           = dst_port_q;
  assign udp_if.m_udp_source_ip           = src_ip_q;
  assign udp_if.m_udp_dest_ip             = dst_ip_q;
  assign udp_if.err_short                 = err_short_q;
  assign udp_if.err_long                  = err_long_q;
  assign udp_if.err_oversize              = err_oversize_q;
  assign udp_if.err_tuser                 = err_tuser_q;

endmodule

// File: tb/tb_udp_payload_capture.sv
// Directed bench for udp_payload_capture with a 16-byte buffer, port 53,
// source-or-dest filtering.
module tb_udp_payload_capture;

  localparam int unsigned MaxB = 16;

  logic clk;
  logic rst;

  udp_payload_capture_if #(.MAX_BYTES(MaxB)) bus ();

  udp_payload_capture #(
    .MAX_BYTES   (MaxB),
    .FILTER_PORT (16'd53),
    .FILTER_MODE (2'd2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .udp_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cnt_short = 0, cnt_long = 0, cnt_over = 0, cnt_user = 0;
  int snap_short = 0, snap_long = 0, snap_over = 0, snap_user = 0;

  // Count error pulses, one per high cycle.
  always @(negedge clk) begin
    if (bus.err_short)    cnt_short <= cnt_short + 1;
    if (bus.err_long)     cnt_long  <= cnt_long + 1;
    if (bus.err_oversize) cnt_over  <= cnt_over + 1;
    if (bus.err_tuser)    cnt_user  <= cnt_user + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    int n = 0;
    bus.s_udp_source_port = src;
    bus.s_udp_dest_port   = dst;
    bus.s_udp_source_ip   = {16'hC0A8, src};
    bus.s_udp_dest_ip     = {16'h0A00, dst};
    bus.s_udp_length      = len;
    bus.s_udp_hdr_valid   = 1'b1;
    while (bus.s_udp_hdr_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);
    check_eq("hdr_tready_low", 128'(bus.s_udp_payload_axis_tready), 128'd0);
    @(posedge clk); #1;
    bus.s_udp_hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    bus.s_udp_payload_axis_tdata  = d;
    bus.s_udp_payload_axis_tlast  = last;
    bus.s_udp_payload_axis_tuser  = user;
    bus.s_udp_payload_axis_tvalid = 1'b1;
    while (bus.s_udp_payload_axis_tready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("beat_tready", 128'(bus.s_udp_payload_axis_tready), 128'd1);
    check_eq("beat_hdr_ready_low", 128'(bus.s_udp_hdr_ready), 128'd0);
    @(posedge clk); #1;
    bus.s_udp_payload_axis_tvalid = 1'b0;
    bus.s_udp_payload_axis_tlast  = 1'b0;
    bus.s_udp_payload_axis_tuser  = 1'b0;
  endtask

  // Header plus nbeats bytes base, base+1, ...; tlast (and optional tuser) on the final beat.
  task automatic send_frame(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input int nbeats, input logic [7:0] base,
                            input logic user_last);
    send_hdr(src, dst, len);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(base + 8'(i), i == nbeats - 1, user_last && (i == nbeats - 1));
    end
  endtask

  // Error pulses seen since the previous call, after letting the last one land.
  task automatic check_errs(input string tag, input int s, input int l, input int o,
                            input int u);
    @(posedge clk); #1;
    check_eq({tag, "_err_short"},    128'(cnt_short - snap_short), 128'(s));
    check_eq({tag, "_err_long"},     128'(cnt_long - snap_long),   128'(l));
    check_eq({tag, "_err_oversize"}, 128'(cnt_over - snap_over),   128'(o));
    check_eq({tag, "_err_tuser"},    128'(cnt_user - snap_user),   128'(u));
    snap_short = cnt_short;
    snap_long  = cnt_long;
    snap_over  = cnt_over;
    snap_user  = cnt_user;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_a;
    int bad_rdy;
    int bad_stab;

    rst = 1'b1;
    bus.s_udp_hdr_valid           = 1'b0;
    bus.s_udp_source_port         = '0;
    bus.s_udp_dest_port           = '0;
    bus.s_udp_source_ip           = '0;
    bus.s_udp_dest_ip             = '0;
    bus.s_udp_length              = '0;
    bus.s_udp_payload_axis_tdata  = '0;
    bus.s_udp_payload_axis_tvalid = 1'b0;
    bus.s_udp_payload_axis_tlast  = 1'b0;
    bus.s_udp_payload_axis_tuser  = 1'b0;
    bus.m_pkt_ready               = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd0);
    check_eq("rst_tready", 128'(bus.s_udp_payload_axis_tready), 128'd0);
    check_eq("rst_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_eq("rst_len", 128'(bus.m_pkt_len), 128'd0);
    check_eq("rst_data", bus.m_pkt_data, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_release_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);

    // Clean 12-byte frame to port 53.
    send_frame(16'd1234, 16'd53, 16'd20, 12, 8'h01, 1'b0);
    check_eq("clean_valid", 128'(bus.m_pkt_valid), 128'd1);
    check_eq("clean_len", 128'(bus.m_pkt_len), 128'd12);
    check_eq("clean_data", bus.m_pkt_data, 128'h0102030405060708090A0B0C00000000);
    check_eq("clean_src_port", 128'(bus.m_udp_source_port), 128'd1234);
    check_eq("clean_dst_port", 128'(bus.m_udp_dest_port), 128'd53);
    check_eq("clean_src_ip", 128'(bus.m_udp_source_ip), 128'hC0A804D2);
    check_eq("clean_dst_ip", 128'(bus.m_udp_dest_ip), 128'h0A000035);
    check_errs("clean", 0, 0, 0, 0);
    check_eq("clean_released", 128'(bus.m_pkt_valid), 128'd0);
    check_eq("clean_hdr_ready_back", 128'(bus.s_udp_hdr_ready), 128'd1);

    // Port mismatch: drained silently.
    send_frame(16'd1000, 16'd80, 16'd20, 12, 8'h40, 1'b0);
    check_eq("mismatch_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("mismatch", 0, 0, 0, 0);
    check_eq("mismatch_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);

    // Source-port match, 2-byte payload.
    send_frame(16'd53, 16'd999, 16'd10, 2, 8'h77, 1'b0);
    check_eq("srcmatch_valid", 128'(bus.m_pkt_valid), 128'd1);
    check_eq("srcmatch_len", 128'(bus.m_pkt_len), 128'd2);
    check_eq("srcmatch_data", bus.m_pkt_data, 128'h77780000000000000000000000000000);
    check_errs("srcmatch", 0, 0, 0, 0);

    // Early tlast on beat 5.
    send_frame(16'd7, 16'd53, 16'd20, 5, 8'h50, 1'b0);
    check_eq("short_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("short", 1, 0, 0, 0);

    // No tlast on beat 12, frame ends at beat 14.
    send_frame(16'd7, 16'd53, 16'd20, 14, 8'h60, 1'b0);
    check_eq("long_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("long", 0, 1, 0, 0);
    check_eq("long_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);

    // tuser beats short-frame and exact-length errors.
    send_frame(16'd7, 16'd53, 16'd20, 5, 8'h70, 1'b1);
    check_eq("tuser_short_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("tuser_short", 0, 0, 0, 1);
    send_frame(16'd7, 16'd53, 16'd20, 12, 8'h70, 1'b1);
    check_eq("tuser_exact_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("tuser_exact", 0, 0, 0, 1);

    // Header length below 8.
    send_frame(16'd53, 16'd53, 16'd4, 2, 8'h80, 1'b0);
    check_eq("shorthdr_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_errs("shorthdr", 1, 0, 0, 0);

    // Oversize: 32-byte payload into a 16-byte buffer.
    send_hdr(16'd7, 16'd53, 16'd40);
    for (int i = 0; i < 32; i++) begin
      send_beat(8'hA0 + 8'(i), i == 31, 1'b0);
      if (i == 15) check_eq("ovs_before_beat17", 128'(bus.err_oversize), 128'd0);
      if (i == 16) begin
        check_eq("ovs_on_beat17", 128'(bus.err_oversize), 128'd1);
        check_eq("ovs_buf_beat17", bus.m_pkt_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      end
    end
    check_eq("ovs_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_eq("ovs_buf_end", bus.m_pkt_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check_errs("ovs", 0, 0, 1, 0);

    // Consumer stalls 50 cycles with a second header waiting.
    bus.m_pkt_ready = 1'b0;
    send_frame(16'd1111, 16'd53, 16'd12, 4, 8'hD0, 1'b0);
    exp_a = 128'hD0D1D2D3000000000000000000000000;
    check_eq("holdA_valid", 128'(bus.m_pkt_valid), 128'd1);
    check_eq("holdA_data", bus.m_pkt_data, exp_a);
    bus.s_udp_source_port = 16'd9;
    bus.s_udp_dest_port   = 16'd53;
    bus.s_udp_source_ip   = 32'hC0A80009;
    bus.s_udp_dest_ip     = 32'h0A000035;
    bus.s_udp_length      = 16'd11;
    bus.s_udp_hdr_valid   = 1'b1;
    bad_rdy  = 0;
    bad_stab = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (bus.s_udp_hdr_ready !== 1'b0) bad_rdy++;
      if (bus.m_pkt_valid !== 1'b1 || bus.m_pkt_len !== 16'd4 || bus.m_pkt_data !== exp_a ||
          bus.m_udp_source_port !== 16'd1111 || bus.s_udp_payload_axis_tready !== 1'b0)
        bad_stab++;
    end
    check_eq("hold_hdr_ready_low", 128'(bad_rdy), 128'd0);
    check_eq("hold_outputs_stable", 128'(bad_stab), 128'd0);
    bus.m_pkt_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("hold_release_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_eq("hold_release_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);
    @(posedge clk); #1;
    bus.s_udp_hdr_valid = 1'b0;
    check_eq("holdB_tready", 128'(bus.s_udp_payload_axis_tready), 128'd1);
    for (int i = 0; i < 3; i++) send_beat(8'h55 + 8'h11 * 8'(i), i == 2, 1'b0);
    check_eq("holdB_valid", 128'(bus.m_pkt_valid), 128'd1);
    check_eq("holdB_len", 128'(bus.m_pkt_len), 128'd3);
    check_eq("holdB_data", bus.m_pkt_data, 128'h55667700000000000000000000000000);
    check_eq("holdB_src_port", 128'(bus.m_udp_source_port), 128'd9);
    check_errs("holdB", 0, 0, 0, 0);

    // Reset on beat 4 of a 12-byte frame.
    send_hdr(16'd2222, 16'd53, 16'd20);
    for (int i = 0; i < 3; i++) send_beat(8'h21 + 8'(i), 1'b0, 1'b0);
    bus.s_udp_payload_axis_tdata  = 8'h24;
    bus.s_udp_payload_axis_tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.s_udp_payload_axis_tvalid = 1'b0;
    check_eq("midrst_valid", 128'(bus.m_pkt_valid), 128'd0);
    check_eq("midrst_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd0);
    check_eq("midrst_tready", 128'(bus.s_udp_payload_axis_tready), 128'd0);
    check_eq("midrst_len", 128'(bus.m_pkt_len), 128'd0);
    check_eq("midrst_data", bus.m_pkt_data, 128'd0);
    check_eq("midrst_src_port", 128'(bus.m_udp_source_port), 128'd0);
    check_eq("midrst_dst_ip", 128'(bus.m_udp_dest_ip), 128'd0);
    check_eq("midrst_errs", 128'({bus.err_short, bus.err_long, bus.err_oversize,
                                  bus.err_tuser}), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_release_hdr_ready", 128'(bus.s_udp_hdr_ready), 128'd1);
    send_frame(16'd1234, 16'd53, 16'd20, 12, 8'h01, 1'b0);
    check_eq("postrst_valid", 128'(bus.m_pkt_valid), 128'd1);
    check_eq("postrst_len", 128'(bus.m_pkt_len), 128'd12);
    check_eq("postrst_data", bus.m_pkt_data, 128'h0102030405060708090A0B0C00000000);
    check_errs("postrst", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udp_payload_capture.md
UDP_PAYLOAD_CAPTURE -- requirements
Module: udp_payload_capture

Interface
REQ-001 Parameter MAX_BYTES, 512, payload buffer capacity in bytes; legal range 8..1024.
REQ-002 Parameter FILTER_PORT, 16'd53, UDP port to match.
REQ-003 Parameter FILTER_MODE, 2, port-match rule: 0 = any port, 1 = dest only, 2 = source or dest, 3 = source only.
REQ-004 clk  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_udp_hdr_valid/s_udp_hdr_ready  in/out  1/1  UDP header handshake.
REQ-007 s_udp_source_port, s_udp_dest_port  in  16  header ports; s_udp_source_ip, s_udp_dest_ip  in  32  header IPs; s_udp_length  in  16  UDP length including 8-byte header.
REQ-008 s_udp_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  payload byte stream.
REQ-009 m_pkt_valid/m_pkt_ready  out/in  1/1  captured-packet handshake.
REQ-010 m_udp_source_port, m_udp_dest_port  out  16; m_udp_source_ip, m_udp_dest_ip  out  32  latched header fields.
REQ-011 m_pkt_len  out  16  payload byte count; m_pkt_data  out  8*MAX_BYTES  payload, byte 0 at bits [8*MAX_BYTES-1 -: 8], byte i at [8*MAX_BYTES-1-8*i -: 8].
REQ-012 err_short, err_long, err_oversize, err_tuser  out  1 each  single-cycle error pulses.

Function
REQ-013 States: IDLE, CAPTURE, DRAIN, HOLD.
REQ-014 IDLE: s_udp_hdr_ready = 1 only when m_pkt_valid = 0; on header accept, latch all header fields, set expected = s_udp_length - 8, clear count and buffer; go to CAPTURE if the port matches, else DRAIN.
REQ-015 Header with s_udp_length < 8 goes to DRAIN with err_short pulsed on its final beat.
REQ-016 CAPTURE: tready = 1; each accepted beat writes byte[count] and increments count (saturating at MAX_BYTES).
REQ-017 tlast with count+1 == expected and tuser = 0 -> m_pkt_len = expected, m_pkt_valid = 1 on the next cycle, state HOLD.
REQ-018 tlast with count+1 < expected -> err_short, no output, IDLE.
REQ-019 Beat with count+1 == expected and tlast = 0 -> err_long, DRAIN.
REQ-020 Beat at count == MAX_BYTES (expected > MAX_BYTES) -> err_oversize, DRAIN; bytes are never written beyond MAX_BYTES.
REQ-021 tlast with tuser = 1 -> err_tuser (takes priority over other errors on that beat), no output, IDLE.
REQ-022 DRAIN: tready = 1; discard beats until tlast, then IDLE; port mismatch pulses no error.
REQ-023 HOLD: tready = 0, hdr_ready = 0; m_pkt_* stable until m_pkt_valid & m_pkt_ready; on that handshake, m_pkt_valid = 0 and state IDLE, so hdr_ready = 1 on the following cycle.
REQ-024 Bytes at index >= m_pkt_len read as 0.
REQ-025 Only one error pulse fires per frame.
REQ-026 Header and payload handshakes never occur in the same cycle.

Reset
REQ-027 rst returns the block to IDLE and clears m_pkt_valid, s_udp_hdr_ready, s_udp_payload_axis_tready, all error pulses, m_pkt_len, the header outputs and m_pkt_data, mid-frame included; there is no partial output and the next header is accepted normally.
REQ-028 s_udp_hdr_ready rises on the first cycle after rst deasserts.

Structure
REQ-029 A shared package holds the state encoding, the FILTER_MODE encodings and the UDP_HDR_BYTES = 8 constant.
REQ-030 One sub-module, udp_port_match, implements the combinational FILTER_MODE compare.
REQ-031 The buffer is a flat register array written one byte per beat with no read port besides m_pkt_data.

Verification
REQ-032 dest=53, length=20, 12 clean beats 0x01..0x0C, ready held -> m_pkt_len=12, m_pkt_data MSB byte=0x01, byte 11=0x0C, remaining bytes 0.
REQ-033 dest=80, FILTER_MODE=2, length=20 -> all 12 beats accepted, no m_pkt_valid, no error pulse.
REQ-034 length=20, tlast on beat 5 -> err_short pulse, no output; length=20 with tlast absent on beat 12 -> err_long, drain to tlast.
REQ-035 MAX_BYTES=16, length=40 -> err_oversize on beat 17, buffer bytes 0..15 not overwritten, no output.
REQ-036 m_pkt_ready held 0 for 50 cycles, second header presented -> hdr_ready stays 0 and outputs stay stable; ready pulse -> second frame then captured correctly.
REQ-037 rst asserted on beat 4 of 12 -> all outputs 0; next clean frame captured correctly.
